spi_command_sender: RTL and testbench

- SPI mode-0 master transmitter in the FPGA clock domain. It generates the frames that the sprite SPI slave path consumes: one command byte followed by N payload bytes, MSB first, with spi_cs held low for the whole frame.
- Used as the board-to-board uplink and as the stimulus engine for system benches of the sprite upload/draw path.
- MISO is sampled in parallel and returned byte-wise.

---
 rtl/spi_command_sender_if.sv | 25 ++
 rtl/spi_command_sender.sv | 163 ++++++++++++++++
 tb/tb_spi_command_sender.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_command_sender_if.sv
// Request/payload/receive handshake bundle between a frame producer and spi_command_sender.
// The producer side uses the master modport; the sender uses the slave modport.
interface spi_command_sender_if #(
    parameter int LEN_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_byte;
    logic [LEN_W-1:0] cmd_len;
    logic             data_valid;
    logic             data_ready;
    logic [7:0]       data_byte;
    logic             rx_valid;
    logic [7:0]       rx_byte;

    modport master (
        output cmd_valid, cmd_byte, cmd_len, data_valid, data_byte,
        input  cmd_ready, data_ready, rx_valid, rx_byte
    );

    modport slave (
        input  cmd_valid, cmd_byte, cmd_len, data_valid, data_byte,
        output cmd_ready, data_ready, rx_valid, rx_byte
    );
endinterface

// File: rtl/spi_command_sender.sv
// SPI mode-0 master: sends one command byte plus cmd_len payload bytes MSB first under a single
// chip-select, samples MISO on each rising SPI clock and returns completed bytes.
module spi_command_sender #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    spi_command_sender_if.slave  bus,
    output logic                 spi_clk,
    output logic                 spi_mosi,
    output logic                 spi_cs,
    input  logic                 spi_miso,
    output logic                 busy
);
    localparam int              PW         = $clog2(CLK_DIV) + 1;
    localparam logic [PW-1:0]   PHASE_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        WAIT_DATA,
        HOLD,
        GAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PW-1:0]    phase_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       tx_shift;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_byte_q;
    logic             rx_valid_q;
    logic [LEN_W-1:0] remaining;
    logic             phase_done;
    logic             timed_state;
    logic             accept;
    logic             take;
    logic             cmd_ready_c;
    logic             data_ready_c;

    assign phase_done  = (phase_cnt == PHASE_LAST);
    assign timed_state = (state == LO) || (state == HI) || (state == HOLD) || (state == GAP);
    assign accept      = (state == IDLE) && bus.cmd_valid;
    assign take        = (state == WAIT_DATA) && bus.data_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept) state_next = LO;
            LO:        if (phase_done) state_next = HI;
            HI: begin
                if (phase_done) begin
                    if (bit_idx != 3'd0)          state_next = LO;
                    else if (remaining != '0)     state_next = WAIT_DATA;
                    else                          state_next = HOLD;
                end
            end
            WAIT_DATA: if (take) state_next = LO;
            HOLD:      if (phase_done) state_next = GAP;
            GAP:       if (phase_done) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Shift data, bit/byte bookkeeping and MISO capture; MISO is taken on the last LO cycle,
    // which is the cycle whose closing edge raises spi_clk.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_cnt  <= '0;
            bit_idx    <= 3'd0;
            tx_shift   <= 8'h00;
            rx_shift   <= 8'h00;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            remaining  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            if (timed_state && !phase_done) begin
                phase_cnt <= phase_cnt + 1'b1;
            end else begin
                phase_cnt <= '0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_shift  <= bus.cmd_byte;
                        remaining <= bus.cmd_len;
                        bit_idx   <= 3'd7;
                    end
                end
                LO: begin
                    if (phase_done) rx_shift <= {rx_shift[6:0], spi_miso};
                end
                HI: begin
                    if (phase_done) begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        if (bit_idx != 3'd0) begin
                            bit_idx <= bit_idx - 3'd1;
                        end else begin
                            rx_valid_q <= 1'b1;
                            rx_byte_q  <= rx_shift;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (take) begin
                        tx_shift  <= bus.data_byte;
                        remaining <= remaining - 1'b1;
                        bit_idx   <= 3'd7;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        spi_clk      = 1'b0;
        spi_cs       = 1'b1;
        spi_mosi     = 1'b0;
        cmd_ready_c  = 1'b0;
        data_ready_c = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready_c = 1'b1;
                busy        = 1'b0;
            end
            LO: begin
                spi_cs   = 1'b0;
                spi_mosi = tx_shift[7];
            end
            HI: begin
                spi_cs   = 1'b0;
                spi_clk  = 1'b1;
                spi_mosi = tx_shift[7];
            end
            WAIT_DATA: begin
                spi_cs       = 1'b0;
                data_ready_c = 1'b1;
            end
            HOLD:    spi_cs = 1'b0;
            default: ;
        endcase
    end

    // The reset term keeps cmd_ready low while reset_n is held, even though state reads IDLE.
    assign bus.cmd_ready  = cmd_ready_c & reset_n;
    assign bus.data_ready = data_ready_c;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.rx_byte    = rx_byte_q;
endmodule

// File: tb/tb_spi_command_sender.sv
// Self-checking bench: directed and random frames on a CLK_DIV=2 instance checked against a
// frame-level model, plus a CLK_DIV=1 instance exercised with back-to-back requests.
module tb_spi_command_sender;
    localparam int LEN_W = 16;
    localparam int DIV_A = 2;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    spi_command_sender_if #(.LEN_W(LEN_W)) bus_a ();
    spi_command_sender_if #(.LEN_W(LEN_W)) bus_b ();

    logic a_clk, a_mosi, a_cs, a_miso, a_busy;
    logic b_clk, b_mosi, b_cs, b_miso, b_busy;
    logic miso_invert;

    assign a_miso = a_mosi ^ miso_invert;
    assign b_miso = 1'b0;

    spi_command_sender #(.CLK_DIV(DIV_A), .LEN_W(LEN_W)) dut_a (
        .clock(clock), .reset_n(reset_n), .bus(bus_a),
        .spi_clk(a_clk), .spi_mosi(a_mosi), .spi_cs(a_cs), .spi_miso(a_miso), .busy(a_busy)
    );

    spi_command_sender #(.CLK_DIV(1), .LEN_W(LEN_W)) dut_b (
        .clock(clock), .reset_n(reset_n), .bus(bus_b),
        .spi_clk(b_clk), .spi_mosi(b_mosi), .spi_cs(b_cs), .spi_miso(b_miso), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wire-level observer for instance A, sampled mid-way through the low clock phase.
    int         cs_low_cnt = 0;
    int         gap_cnt    = 0;
    int         hs_cnt     = 0;
    int         ready_bad  = 0;
    int         bit_cnt    = 0;
    logic [7:0] sh         = 8'h00;
    logic       prev_clk   = 1'b0;
    logic [7:0] wire_q[$];
    logic [7:0] rx_q[$];

    always @(negedge clock) begin
        #2;
        if (!a_cs) cs_low_cnt++;
        if (a_cs && a_busy) gap_cnt++;
        if (a_cs) bit_cnt = 0;
        if (a_clk && !prev_clk) begin
            sh = {sh[6:0], a_mosi};
            bit_cnt++;
            if (bit_cnt == 8) begin
                wire_q.push_back(sh);
                bit_cnt = 0;
            end
        end
        prev_clk = a_clk;
        if (bus_a.data_valid && bus_a.data_ready) hs_cnt++;
        if (bus_a.data_ready && (a_cs || a_clk)) ready_bad++;
        if (bus_a.rx_valid) rx_q.push_back(bus_a.rx_byte);
    end

    // Instance B observer: a len-0 frame at CLK_DIV=1 is 17 cs-low cycles with spi_clk high on
    // the odd cycles 1..15.
    int         b_k        = 0;
    int         b_frames   = 0;
    int         b_shape_bad = 0;
    int         b_len_bad  = 0;
    int         b_byte_bad = 0;
    int         b_high_run = 0;
    int         b_gap_min  = 1000;
    logic [7:0] b_sh       = 8'h00;
    logic       b_prev_clk = 1'b0;

    always @(negedge clock) begin
        #2;
        if (!b_cs) begin
            if (b_k == 0 && b_frames > 0 && b_high_run < b_gap_min) b_gap_min = b_high_run;
            if (b_clk !== ((b_k < 16) && (b_k % 2 == 1))) b_shape_bad++;
            if (b_clk && !b_prev_clk) b_sh = {b_sh[6:0], b_mosi};
            b_k++;
            b_high_run = 0;
        end else begin
            if (b_k != 0) begin
                b_frames++;
                if (b_k != 17) b_len_bad++;
                if (b_sh !== 8'h96) b_byte_bad++;
            end
            b_k = 0;
            b_high_run++;
        end
        b_prev_clk = b_clk;
    end

    logic [7:0] pay   [0:7];
    int         stall [0:7];

    task automatic clearStalls();
        for (int i = 0; i < 8; i++) stall[i] = 0;
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input int len, input bit always_valid,
                                 input logic inv, input string tag);
        int         cs0, gap0, hs0, rb0, w0, r0, extra, tmo, stall_bad, n_wire, n_rx;
        logic [7:0] exp_q[$];
        @(negedge clock);
        miso_invert = inv;
        cs0 = cs_low_cnt; gap0 = gap_cnt; hs0 = hs_cnt; rb0 = ready_bad;
        w0 = wire_q.size(); r0 = rx_q.size();
        exp_q.push_back(cmd);
        extra = 0;
        stall_bad = 0;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(pay[i]);
            extra += stall[i];
        end
        tmo = 0;
        while (!bus_a.cmd_ready && tmo < 200) begin
            @(negedge clock);
            tmo++;
        end
        checkOutput($sformatf("%s_cmd_ready", tag), 32'(bus_a.cmd_ready), 32'd1);
        bus_a.cmd_byte   = cmd;
        bus_a.cmd_len    = LEN_W'(len);
        bus_a.cmd_valid  = 1'b1;
        bus_a.data_valid = always_valid;
        bus_a.data_byte  = (len > 0) ? pay[0] : 8'h00;
        @(negedge clock);
        bus_a.cmd_valid = 1'b0;
        bus_a.cmd_len   = LEN_W'($urandom);
        bus_a.cmd_byte  = 8'($urandom);
        for (int i = 0; i < len; i++) begin
            bus_a.data_byte = pay[i];
            if (!always_valid) bus_a.data_valid = 1'b0;
            tmo = 0;
            while (!bus_a.data_ready && tmo < 500) begin
                @(negedge clock);
                tmo++;
            end
            if (!bus_a.data_ready) begin
                checkOutput($sformatf("%s_data_ready_timeout", tag), 32'(bus_a.data_ready), 32'd1);
                break;
            end
            for (int s = 0; s < stall[i]; s++) begin
                bus_a.data_valid = 1'b0;
                @(negedge clock);
                if (a_clk || a_cs) stall_bad++;
            end
            bus_a.data_valid = 1'b1;
            @(negedge clock);
        end
        bus_a.data_valid = always_valid;
        tmo = 0;
        while (a_busy && tmo < 3000) begin
            @(negedge clock);
            tmo++;
        end
        @(negedge clock);
        #3;
        bus_a.data_valid = 1'b0;
        n_wire = wire_q.size() - w0;
        n_rx   = rx_q.size() - r0;
        checkOutput($sformatf("%s_idle", tag), 32'(a_busy), 32'd0);
        checkOutput($sformatf("%s_cs_low", tag), 32'(cs_low_cnt - cs0),
                    32'(16 * DIV_A * (len + 1) + len + DIV_A + extra));
        checkOutput($sformatf("%s_gap", tag), 32'(gap_cnt - gap0), 32'(DIV_A));
        checkOutput($sformatf("%s_handshakes", tag), 32'(hs_cnt - hs0), 32'(len));
        checkOutput($sformatf("%s_ready_outside_wait", tag), 32'(ready_bad - rb0), 32'd0);
        checkOutput($sformatf("%s_stall_lines", tag), 32'(stall_bad), 32'd0);
        checkOutput($sformatf("%s_n_wire", tag), 32'(n_wire), 32'(len + 1));
        for (int i = 0; i <= len && i < n_wire; i++)
            checkOutput($sformatf("%s_wire%0d", tag, i), 32'(wire_q[w0 + i]), 32'(exp_q[i]));
        checkOutput($sformatf("%s_n_rx", tag), 32'(n_rx), 32'(len + 1));
        for (int i = 0; i <= len && i < n_rx; i++)
            checkOutput($sformatf("%s_rx%0d", tag, i), 32'(rx_q[r0 + i]),
                        32'(exp_q[i] ^ {8{inv}}));
    endtask

    initial begin
        int  len, tmo, w0;
        bit  av;
        reset_n          = 1'b0;
        miso_invert      = 1'b0;
        bus_a.cmd_valid  = 1'b0; bus_a.cmd_byte = 8'h00; bus_a.cmd_len = '0;
        bus_a.data_valid = 1'b0; bus_a.data_byte = 8'h00;
        bus_b.cmd_valid  = 1'b0; bus_b.cmd_byte = 8'h00; bus_b.cmd_len = '0;
        bus_b.data_valid = 1'b0; bus_b.data_byte = 8'h00;
        clearStalls();

        #12;
        checkOutput("rst_cs", 32'(a_cs), 32'd1);
        checkOutput("rst_clk", 32'(a_clk), 32'd0);
        checkOutput("rst_mosi", 32'(a_mosi), 32'd0);
        checkOutput("rst_cmd_ready", 32'(bus_a.cmd_ready), 32'd0);
        checkOutput("rst_data_ready", 32'(bus_a.data_ready), 32'd0);
        checkOutput("rst_rx", {23'd0, bus_a.rx_valid, bus_a.rx_byte}, 32'd0);
        checkOutput("rst_busy", 32'(a_busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("post_rst_cmd_ready", 32'(bus_a.cmd_ready), 32'd1);

        applyStimulus(8'h01, 0, 1'b0, 1'b0, "cmd01_len0");

        pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'hFF;
        applyStimulus(8'h02, 3, 1'b1, 1'b0, "cmd02_len3");

        pay[0] = 8'h81; pay[1] = 8'h42; pay[2] = 8'h18;
        stall[0] = 20;
        applyStimulus(8'hE7, 3, 1'b0, 1'b0, "stall20");
        clearStalls();

        pay[0] = 8'hC3;
        applyStimulus(8'h5A, 1, 1'b0, 1'b0, "loopback");

        // Abort a frame part-way through its second byte.
        @(negedge clock);
        miso_invert = 1'b0;
        w0 = wire_q.size();
        bus_a.cmd_byte = 8'h77; bus_a.cmd_len = LEN_W'(2); bus_a.cmd_valid = 1'b1;
        bus_a.data_byte = 8'h99; bus_a.data_valid = 1'b1;
        @(negedge clock);
        bus_a.cmd_valid = 1'b0;
        tmo = 0;
        while (wire_q.size() == w0 && tmo < 200) begin
            @(negedge clock);
            tmo++;
        end
        repeat (6) @(negedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_cs", 32'(a_cs), 32'd1);
        checkOutput("midrst_clk", 32'(a_clk), 32'd0);
        checkOutput("midrst_mosi", 32'(a_mosi), 32'd0);
        checkOutput("midrst_busy", 32'(a_busy), 32'd0);
        checkOutput("midrst_cmd_ready", 32'(bus_a.cmd_ready), 32'd0);
        checkOutput("midrst_rx", {23'd0, bus_a.rx_valid, bus_a.rx_byte}, 32'd0);
        bus_a.data_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("midrst_release_ready", 32'(bus_a.cmd_ready), 32'd1);
        applyStimulus(8'h01, 0, 1'b0, 1'b0, "after_reset");

        for (int f = 0; f < 12; f++) begin
            len = $urandom_range(0, 4);
            av  = $urandom_range(0, 3) == 0;
            for (int i = 0; i < 8; i++) begin
                pay[i]   = 8'($urandom);
                stall[i] = (!av && $urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : 0;
            end
            applyStimulus(8'($urandom), len, av, 1'($urandom), $sformatf("rand%0d", f));
        end
        clearStalls();

        // Back-to-back requests on the CLK_DIV=1 instance.
        @(negedge clock);
        bus_b.cmd_byte  = 8'h96;
        bus_b.cmd_len   = '0;
        bus_b.cmd_valid = 1'b1;
        tmo = 0;
        while (b_frames < 5 && tmo < 500) begin
            @(negedge clock);
            tmo++;
        end
        bus_b.cmd_valid = 1'b0;
        tmo = 0;
        while (b_busy && tmo < 100) begin
            @(negedge clock);
            tmo++;
        end
        repeat (3) @(negedge clock);
        checkOutput("b2b_frames", 32'(b_frames >= 5), 32'd1);
        checkOutput("b2b_clk_shape", 32'(b_shape_bad), 32'd0);
        checkOutput("b2b_cs_len", 32'(b_len_bad), 32'd0);
        checkOutput("b2b_byte", 32'(b_byte_bad), 32'd0);
        checkOutput("b2b_cs_gap", 32'(b_gap_min >= 1), 32'd1);
        checkOutput("b2b_data_ready", 32'(bus_b.data_ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
